// File: rtl/kbd_vmem_writer.sv
// PS/2 scan-code set 2 to ASCII, writing characters and line clears into the column-major text vmem.
// Optional macro KBD_AUTOREPEAT_EN: when defined, held printable keys repeat with every make byte.
module kbd_vmem_writer #(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic        kb_ready,
  output logic        vm_we,
  output logic [11:0] vm_addr,
  output logic [7:0]  vm_wdata,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [11:0] INIT_END = 12'(COLS * 32);
  localparam logic [11:0] CLR_END  = 12'(COLS);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLRLINE} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        brk_q, brk_d, ext_q, ext_d;
  logic        lsh_q, lsh_d, rsh_q, rsh_d, caps_q, caps_d;
  logic        we_q, we_d, ready_q, ready_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;

  // Returns {printable, ascii}; letters flip case on 'upper', digit row uses 'shift'.
  function automatic logic [8:0] key_to_ascii(input logic [7:0] code, input logic shift,
                                              input logic upper);
    logic [7:0] letter, digit, symbol;
    letter = 8'h00; digit = 8'h00; symbol = 8'h00;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      8'h16: begin digit = 8'h31; symbol = 8'h21; end
      8'h1E: begin digit = 8'h32; symbol = 8'h40; end
      8'h26: begin digit = 8'h33; symbol = 8'h23; end
      8'h25: begin digit = 8'h34; symbol = 8'h24; end
      8'h2E: begin digit = 8'h35; symbol = 8'h25; end
      8'h36: begin digit = 8'h36; symbol = 8'h5E; end
      8'h3D: begin digit = 8'h37; symbol = 8'h26; end
      8'h3E: begin digit = 8'h38; symbol = 8'h2A; end
      8'h46: begin digit = 8'h39; symbol = 8'h28; end
      8'h45: begin digit = 8'h30; symbol = 8'h29; end
      8'h29: begin digit = 8'h20; symbol = 8'h20; end
      default: ;
    endcase
    if (letter != 8'h00)     key_to_ascii = {1'b1, upper ? (letter - 8'h20) : letter};
    else if (digit != 8'h00) key_to_ascii = {1'b1, shift ? symbol : digit};
    else                     key_to_ascii = 9'h000;
  endfunction

  logic       accept, prefix, is_make, is_rel, rpt_hit;
  logic [8:0] key;
  logic [4:0] row_next;

  assign accept   = kb_valid && ready_q;
  assign prefix   = (kb_data == 8'hF0) || (kb_data == 8'hE0);
  assign is_make  = accept && !prefix && !ext_q && !brk_q;
  assign is_rel   = accept && !prefix && !ext_q && brk_q;
  assign key      = key_to_ascii(kb_data, lsh_q || rsh_q, (lsh_q || rsh_q) ^ caps_q);
  assign row_next = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

`ifdef KBD_AUTOREPEAT_EN
  assign rpt_hit = 1'b0;
`else
  // Remembers the last make so a held key's typematic bytes are swallowed until release.
  logic [7:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (is_make) begin
      last_d     = kb_data;
      last_vld_d = 1'b1;
    end else if (is_rel && kb_data == last_q) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q     <= 8'h00;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign rpt_hit = last_vld_q && (last_q == kb_data) &&
                   (key[8] || kb_data == 8'h5A || kb_data == 8'h66);
`endif

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;
    brk_d   = brk_q;    ext_d   = ext_q;
    lsh_d   = lsh_q;    rsh_d   = rsh_q;   caps_d = caps_q;
    we_d    = 1'b0;     addr_d  = addr_q;  wdata_d = wdata_q;
    col_d   = col_q;    row_d   = row_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_END) begin
          state_d = S_IDLE;
          cnt_d   = 12'd0;
        end else begin
          we_d = 1'b1;  addr_d = cnt_q;  wdata_d = BLANK;  cnt_d = cnt_q + 12'd1;
        end
      end
      S_CLRLINE: begin
        // The extra pass with cnt==COLS keeps kb_ready low through the last clear write.
        if (cnt_q == CLR_END) begin
          state_d = S_IDLE;
        end else begin
          we_d = 1'b1;  addr_d = {cnt_q[6:0], row_q};  wdata_d = BLANK;  cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        if (accept) begin
          if (kb_data == 8'hF0)      brk_d = 1'b1;
          else if (kb_data == 8'hE0) ext_d = 1'b1;
          else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
          if (is_rel) begin
            if (kb_data == 8'h12) lsh_d = 1'b0;
            if (kb_data == 8'h59) rsh_d = 1'b0;
          end
          if (is_make && !rpt_hit) begin
            case (kb_data)
              8'h12: lsh_d  = 1'b1;
              8'h59: rsh_d  = 1'b1;
              8'h58: caps_d = !caps_q;
              8'h5A: begin
                // Enter issues column 0 of the clear itself, so CLRLINE resumes at column 1.
                col_d = 7'd0;  row_d = row_next;
                we_d  = 1'b1;  addr_d = {7'd0, row_next};  wdata_d = BLANK;
                cnt_d = 12'd1; state_d = S_CLRLINE;
              end
              8'h66: begin
                if (col_q != 7'd0) begin
                  col_d = col_q - 7'd1;
                  we_d  = 1'b1;  addr_d = {col_q - 7'd1, row_q};  wdata_d = BLANK;
                end else if (row_q != 5'd0) begin
                  col_d = LAST_COL;  row_d = row_q - 5'd1;
                  we_d  = 1'b1;  addr_d = {LAST_COL, row_q - 5'd1};  wdata_d = BLANK;
                end
              end
              default: begin
                if (key[8]) begin
                  we_d = 1'b1;  addr_d = {col_q, row_q};  wdata_d = key[7:0];
                  if (col_q == LAST_COL) begin
                    col_d = 7'd0;  row_d = row_next;  cnt_d = 12'd0;  state_d = S_CLRLINE;
                  end else begin
                    col_d = col_q + 7'd1;
                  end
                end
              end
            endcase
          end
        end
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_INIT;  cnt_q  <= 12'd0;
      brk_q   <= 1'b0;    ext_q  <= 1'b0;
      lsh_q   <= 1'b0;    rsh_q  <= 1'b0;   caps_q  <= 1'b0;
      we_q    <= 1'b0;    addr_q <= 12'd0;  wdata_q <= BLANK;
      col_q   <= 7'd0;    row_q  <= 5'd0;   ready_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q  <= cnt_d;
      brk_q   <= brk_d;   ext_q  <= ext_d;
      lsh_q   <= lsh_d;   rsh_q  <= rsh_d;  caps_q  <= caps_d;
      we_q    <= we_d;    addr_q <= addr_d; wdata_q <= wdata_d;
      col_q   <= col_d;   row_q  <= row_d;  ready_q <= ready_d;
    end
  end

  assign kb_ready = ready_q;
  assign vm_we    = we_q;
  assign vm_addr  = addr_q;
  assign vm_wdata = wdata_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;
endmodule

// File: tb/tb_kbd_vmem_writer.sv
// Bench for kbd_vmem_writer: directed sequences plus random scan codes against a queue-based model.
module tb_kbd_vmem_writer;
  localparam int NCOL = 70;
  localparam int NROW = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_valid = 1'b0;
  logic        kb_ready, vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_wdata;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  kbd_vmem_writer dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_valid(kb_valid), .kb_ready(kb_ready),
    .vm_we(vm_we), .vm_addr(vm_addr), .vm_wdata(vm_wdata), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int wr_cnt = 0, rdy_lo = 0, distinct = 0;
  bit seen [2240];
  logic [11:0] last_addr = 12'd0;
  logic [7:0]  last_data = 8'd0;

  logic [7:0] lcode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dcode [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  string lchars = "abcdefghijklmnopqrstuvwxyz";
  string uchars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  string dchars = "1234567890";
  string schars = "!@#$%^&*()";

  // Behavioural model state
  bit          live = 0;
  bit          m_brk, m_ext, m_lsh, m_rsh, m_caps, m_lm_vld, m_ready, m_init_pend, m_direct;
  logic [7:0]  m_lm;
  int          m_col = 0, m_row = 0;
  int unsigned m_dwr;
  int unsigned wq [$];
  bit          e_we, e_rst;
  logic [11:0] e_addr;
  logic [7:0]  e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic int lookup(input logic [7:0] b, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (b == lcode[i]) return (sh ^ cp) ? int'(uchars[i]) : int'(lchars[i]);
    for (int i = 0; i < 10; i++)
      if (b == dcode[i]) return sh ? int'(schars[i]) : int'(dchars[i]);
    if (b == 8'h29) return 32;
    return -1;
  endfunction

  task automatic direct(input int c, input int r, input int d);
    m_direct = 1;
    m_dwr = ((c * 32 + r) * 256) + d;
  endtask

  task automatic clear_row(input int r);
    for (int c = 0; c < NCOL; c++) wq.push_back(((c * 32 + r) * 256) + 32);
  endtask

  task automatic m_byte(input logic [7:0] b);
    bit wb, wx, sup;
    int ch;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      wb = m_brk; wx = m_ext; m_brk = 0; m_ext = 0;
      if (!wx && wb) begin
        if (b == 8'h12) m_lsh = 0;
        if (b == 8'h59) m_rsh = 0;
        if (m_lm_vld && b == m_lm) m_lm_vld = 0;
      end else if (!wx) begin
        ch = lookup(b, m_lsh | m_rsh, m_caps);
        sup = 0;
`ifndef KBD_AUTOREPEAT_EN
        sup = (ch >= 0 || b == 8'h5A || b == 8'h66) && m_lm_vld && b == m_lm;
`endif
        m_lm = b; m_lm_vld = 1;
        if (!sup) begin
          if (b == 8'h12) m_lsh = 1;
          else if (b == 8'h59) m_rsh = 1;
          else if (b == 8'h58) m_caps = !m_caps;
          else if (b == 8'h5A) begin
            m_col = 0; m_row = (m_row + 1) % NROW; clear_row(m_row);
          end else if (b == 8'h66) begin
            if (m_col > 0) begin m_col--; direct(m_col, m_row, 32); end
            else if (m_row > 0) begin m_col = NCOL - 1; m_row--; direct(m_col, m_row, 32); end
          end else if (ch >= 0) begin
            direct(m_col, m_row, ch);
            if (m_col == NCOL - 1) begin
              m_col = 0; m_row = (m_row + 1) % NROW; clear_row(m_row);
            end else m_col++;
          end
        end
      end
    end
  endtask

  // Expected outputs for the cycle following each rising edge
  task automatic model_step();
    bit popped;
    int unsigned w;
    live = 1;
    if (!rst) begin
      m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_lm_vld = 0; m_lm = 0;
      m_col = 0; m_row = 0; m_ready = 0; m_init_pend = 1; wq.delete();
      e_we = 0; e_addr = 0; e_data = 8'h20; e_rst = 1;
    end else begin
      e_rst = 0; m_direct = 0; popped = 0; w = 0;
      if (m_init_pend) begin
        for (int a = 0; a < NCOL * 32; a++) wq.push_back(a * 256 + 32);
        m_init_pend = 0;
      end
      if (m_ready && kb_valid) m_byte(kb_data);
      if (m_direct) w = m_dwr;
      else if (wq.size() > 0) begin w = wq.pop_front(); popped = 1; end
      e_we = m_direct || popped;
      if (e_we) begin e_addr = w[19:8]; e_data = w[7:0]; end
      m_ready = !popped && wq.size() == 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("vm_we", vm_we, e_we);
      if (e_we || e_rst) begin
        chk("vm_addr", vm_addr, e_addr);
        chk("vm_wdata", vm_wdata, e_data);
      end
      chk("kb_ready", kb_ready, m_ready);
      chk("cur_col", cur_col, m_col);
      chk("cur_row", cur_row, m_row);
      if (vm_we === 1'b1) begin
        wr_cnt++; last_addr = vm_addr; last_data = vm_wdata;
        if (vm_addr < 2240 && !seen[vm_addr]) begin seen[vm_addr] = 1; distinct++; end
      end
      if (rst && kb_ready !== 1'b1) rdy_lo++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    int n;
    acc = 0; n = 0;
    kb_data = b; kb_valid = 1'b1;
    do begin
      @(negedge clk); acc = (kb_ready === 1'b1);
      @(posedge clk); #1; n++;
    end while (!acc && n < 5000);
    if (!acc) begin n_total++; $display("FAIL send_timeout: byte %0h never accepted", b); end
    kb_valid = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (kb_ready !== 1'b1 && n < lim);
    if (kb_ready !== 1'b1) begin n_total++; $display("FAIL ready_timeout: kb_ready still %b", kb_ready); end
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick();
    int r, i;
    r = $urandom_range(0, 99);
    if (r < 8)  return 8'hF0;
    if (r < 11) return 8'hE0;
    if (r < 14) return 8'h12;
    if (r < 17) return 8'h59;
    if (r < 19) return 8'h58;
    if (r < 22) return 8'h5A;
    if (r < 28) return 8'h66;
    if (r < 32) return 8'($urandom_range(0, 255));
    i = $urandom_range(0, 36);
    if (i < 26) return lcode[i];
    if (i < 36) return dcode[i - 26];
    return 8'h29;
  endfunction

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_ready(3000);
    chk("init_writes", wr_cnt, 2240);
    chk("init_cover", distinct, 2240);
    chk("init_cursor", {cur_col, cur_row}, 0);

    w0 = wr_cnt;
    send(8'h1C); send(8'hF0); send(8'h1C); idle(2);
    chk("a_cnt", wr_cnt - w0, 1);
    chk("a_addr", last_addr, 0);
    chk("a_data", last_data, 8'h61);
    chk("a_col", cur_col, 1);
    chk("a_row", cur_row, 0);

    send(8'h66); send(8'hF0); send(8'h66);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h58); send(8'h1C); idle(2);
    chk("caps_addr", last_addr, 32);
    chk("caps_data", last_data, 8'h41);
    chk("caps_col", cur_col, 2);
    send(8'hF0); send(8'h1C); send(8'h58); send(8'hF0); send(8'h58);

    send(8'h66); send(8'hF0); send(8'h66); send(8'h66); send(8'hF0); send(8'h66); idle(2);
    chk("bs_col", cur_col, 0);

    w0 = wr_cnt;
    for (int i = 0; i < 70; i++) begin send(8'h29); send(8'hF0); send(8'h29); end
    wait_ready(300);
    chk("sp_cnt", wr_cnt - w0, 140);
    chk("sp_last_addr", last_addr, 69 * 32 + 1);
    chk("sp_cursor", {cur_col, cur_row}, 1);

    for (int i = 0; i < 28; i++) begin send(8'h5A); send(8'hF0); send(8'h5A); end
    wait_ready(300);
    chk("row29", cur_row, 29);
    w0 = wr_cnt;
    send(8'h5A);
    rdy_lo = 0;
    wait_ready(300);
    chk("enter_cnt", wr_cnt - w0, 70);
    chk("enter_busy", rdy_lo, 70);
    chk("enter_cursor", {cur_col, cur_row}, 0);
    send(8'hF0); send(8'h5A);
    w0 = wr_cnt;
    send(8'h66); idle(3);
    chk("bs00_cnt", wr_cnt - w0, 0);
    chk("bs00_cursor", {cur_col, cur_row}, 0);
    send(8'hF0); send(8'h66);

    w0 = wr_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C); idle(2);
`ifdef KBD_AUTOREPEAT_EN
    chk("rep_cnt", wr_cnt - w0, 3);
    chk("rep_col", cur_col, 3);
`else
    chk("rep_cnt", wr_cnt - w0, 1);
    chk("rep_col", cur_col, 1);
`endif
    send(8'hF0); send(8'h1C);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(pick());
    end
    wait_ready(300);

    send(8'h58); send(8'h5A); idle(10);
    rst = 1'b0; idle(2); rst = 1'b1;
    wait_ready(3000);
    chk("mr_cursor", {cur_col, cur_row}, 0);
    w0 = wr_cnt;
    send(8'h1C); idle(2);
    chk("mr_cnt", wr_cnt - w0, 1);
    chk("mr_addr", last_addr, 0);
    chk("mr_data", last_data, 8'h61);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/kbd_vmem_writer.md
# kbd_vmem_writer

Upstream feeder of the VGA text terminal's character memory. Takes PS/2 scan-code set 2 bytes from the keyboard receiver and decodes make/break/extended prefixes, Shift and Caps Lock. It converts keys to ASCII, tracks a text cursor over the 70 × 30 visible grid, and issues write cycles into the column-priority vmem that the VGA scanner reads. It also clears the screen after reset and clears each line as the cursor enters it.

## Interface
- Parameters
  - `COLS`, 70: visible columns.
  - `ROWS`, 30: visible rows; each row slot in vmem is 32 deep.
  - `BLANK`, 8'h20: character code written when clearing.
- Ports
  - `clk` input 1: single clock.
  - `rst` input 1: synchronous, active-low reset.
  - `kb_data` input 8: scan-code byte.
  - `kb_valid` input 1: `kb_data` is valid this cycle.
  - `kb_ready` output 1: block accepts a byte this cycle.
  - `vm_we` output 1: vmem write strobe.
  - `vm_addr` output 12: vmem address `{col[6:0], row[4:0]}`, range 0..2239.
  - `vm_wdata` output 8: character to write.
  - `cur_col` output 7: cursor column, 0..69.
  - `cur_row` output 5: cursor row, 0..29.

## Operation
- States
  - INIT: reset entry. Writes `BLANK` to every address 0..2239 (2240 cycles), then goes to IDLE with cursor (0,0).
  - IDLE: `kb_ready`=1. Processes bytes.
  - CLRLINE: writes `BLANK` to (c, `cur_row`) for c = 0..69 (70 cycles), then returns to IDLE.
- `kb_ready`=1 only in IDLE. A byte is accepted when `kb_valid && kb_ready`.
- Prefix flags:
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Both flags clear after the next non-prefix byte.
  - A non-prefix byte with `ext` set is discarded.
  - A non-prefix byte with `brk` set is a release.
- Modifiers:
  - 0x12 and 0x59 (L/R Shift): make sets, release clears the per-side flag. `shift` is the OR of the two sides.
  - 0x58 (Caps Lock): make toggles `caps`; release is ignored.
- Releases of any other key produce no write.
- Printable makes:
  - Letters 0x1C,0x32,...: lowercase; uppercase when `shift ^ caps`.
  - Digits 0x16..0x45: `0-9`; with `shift`, `!@#$%^&*()`.
  - Space 0x29 → 0x20.
  - Unmapped codes are ignored.
- Printable write: writes the character at the cursor, then advances `cur_col`.
  - At col 69: wrap to col 0 of row+1, or of row 0 when the row was 29, then enter CLRLINE.
- Enter, 0x5A make: col←0, row←row+1 with the same 29→0 wrap, then CLRLINE.
- Backspace, 0x66 make:
  - col>0: col←col−1, write `BLANK` there.
  - col=0, row>0: go to (69, row−1) and write `BLANK`.
  - At (0,0): no write, no move.
- No scrolling. Row wraps to 0.

## Timing
- Reset values:
  - `vm_we`=0, `vm_addr`=0, `vm_wdata`=`BLANK`.
  - `kb_ready`=0, `cur_col`=0, `cur_row`=0.
  - Flags `brk`, `ext`, both shifts and `caps` all 0.
  - State INIT; first INIT write is in the cycle after reset deasserts.
- All outputs are registered.
- A byte accepted in cycle N gives its write (`vm_we`=1, addr, data) in cycle N+1. The cursor update is also visible in N+1.
- Back-to-back bytes in IDLE are accepted every cycle.
- A byte that triggers CLRLINE drops `kb_ready` from N+1. Clear writes occupy N+1..N+70 for Enter, and N+2..N+71 for a wrapping printable. `kb_ready` returns the cycle after the last clear write.
- INIT and CLRLINE issue one write per cycle. `vm_we` stays high throughout.
- Reset asserted mid-INIT or mid-CLRLINE restarts INIT from address 0 and discards all flags.
- `kb_valid` while `kb_ready`=0 is not consumed. The source holds the byte.

## Configuration
- `KBD_AUTOREPEAT_EN` defined: every make byte of a held printable key writes a character (typematic repeat honoured).
- Not defined: a make code equal to the last printable make is ignored until that key's release or a different make arrives. Enter and Backspace follow the same rule.

## Test plan
- Reset for 3 cycles, then release: exactly 2240 writes of 0x20 covering 0..2239. `kb_ready` rises the cycle after address 2239, cursor (0,0).
- Send 0x1C, then F0 1C: one write 'a' (0x61) at addr 0, cursor (1,0). No write for the release.
- Send 12, 1C, F0 12, 58, 1C: writes 'A' (0x41) then 'A' again at cols 0 and 1. Caps-only gives uppercase.
- Send 70 makes of 0x29 (each followed by F0 29): last write at addr {69,0}. Cursor (0,1), then 70 clear writes to row 1 with `kb_ready`=0 for 70 cycles.
- Cursor at (0,29), send 0x5A: cursor (0,0) and row 0 cleared. Then 0x66: no write, cursor stays (0,0).
- Without `KBD_AUTOREPEAT_EN`, send 1C 1C 1C: one write. With it defined: three writes at cols 0..2.
